// File: rtl/fifo_dpram_ctrl_pkg.sv
// Shared defaults for the dual-port-RAM FIFO controller.
package fifo_defs;

  localparam int unsigned DEFAULT_DW        = 16;
  localparam int unsigned DEFAULT_AW        = 6;
  localparam int unsigned DEFAULT_AF_THRESH = 60;
  localparam int unsigned DEPTH             = 1 << DEFAULT_AW;

endpackage

// File: rtl/fifo_dpram_ctrl_ptr.sv
// Wrap pointer: AW address bits plus one wrap bit, incremented on inc_i.
module fifo_ptr
  import fifo_defs::*;
#(
  parameter int unsigned AW = DEFAULT_AW
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  output logic [AW:0] ptr_o
);

  logic [AW:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_dpram_ctrl.sv
// FIFO controller for an external dual-port RAM: pointers, flags, occupancy, push/pop gating.
module fifo_dpram_ctrl
  import fifo_defs::*;
#(
  parameter int unsigned DW        = DEFAULT_DW,
  parameter int unsigned AW        = DEFAULT_AW,
  parameter int unsigned AF_THRESH = DEFAULT_AF_THRESH
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          full_o,
  output logic          almost_full_o,
  output logic          overflow_o,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o,
  output logic          empty_o,
  output logic          underflow_o,
  output logic [AW:0]   count_o,
  output logic          ram_ena_o,
  output logic          ram_wea_o,
  output logic [AW-1:0] ram_addra_o,
  output logic [DW-1:0] ram_dia_o,
  output logic          ram_enb_o,
  output logic [AW-1:0] ram_addrb_o,
  input  logic [DW-1:0] ram_dob_i
);

  localparam logic [AW:0] AfThr = (AW + 1)'(AF_THRESH);

  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] count_q, count_d;
  logic        rd_valid_q, overflow_q, underflow_q;
  logic        full, empty, wr_acc, rd_acc;

  // Flags depend on registered pointers only, never on this cycle's requests.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Gating with rst_i keeps both RAM ports idle for the whole reset interval.
  assign wr_acc = wr_en_i & ~full & ~rst_i;
  assign rd_acc = rd_en_i & ~empty & ~rst_i;

  fifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (wr_acc),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (rd_acc),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= wr_en_i & full;
      underflow_q <= rd_en_i & empty;
    end
  end

  assign full_o        = full;
  assign empty_o       = empty;
  assign almost_full_o = (count_q >= AfThr);
  assign overflow_o    = overflow_q;
  assign underflow_o   = underflow_q;
  assign count_o       = count_q;
  assign rd_valid_o    = rd_valid_q;

  assign ram_ena_o   = wr_acc;
  assign ram_wea_o   = wr_acc;
  assign ram_addra_o = wr_ptr[AW-1:0];
  assign ram_dia_o   = wr_data_i;
  assign ram_enb_o   = rd_acc;
  assign ram_addrb_o = rd_ptr[AW-1:0];

  // Port B holds its address while ram_enb_o is low, so the data stays stable.
  assign rd_data_o = ram_dob_i;

endmodule

// File: tb/tb_fifo_dpram_ctrl.sv
// Bench for fifo_dpram_ctrl with a behavioural 64x16 dual-port RAM and a read-data scoreboard.
module tb_fifo_dpram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        full, almost_full, overflow, rd_valid, empty, underflow;
  logic [15:0] rd_data;
  logic [6:0]  count;
  logic        ram_ena, ram_wea, ram_enb;
  logic [5:0]  ram_addra, ram_addrb;
  logic [15:0] ram_dia, ram_dob;

  fifo_dpram_ctrl #(.DW(16), .AW(6), .AF_THRESH(60)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .wr_en_i       (wr_en),
    .wr_data_i     (wr_data),
    .full_o        (full),
    .almost_full_o (almost_full),
    .overflow_o    (overflow),
    .rd_en_i       (rd_en),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .empty_o       (empty),
    .underflow_o   (underflow),
    .count_o       (count),
    .ram_ena_o     (ram_ena),
    .ram_wea_o     (ram_wea),
    .ram_addra_o   (ram_addra),
    .ram_dia_o     (ram_dia),
    .ram_enb_o     (ram_enb),
    .ram_addrb_o   (ram_addrb),
    .ram_dob_i     (ram_dob)
  );

  always #5 clk = ~clk;

  // External RAM: write port A, registered-address read port B.
  logic [15:0] mem [64];
  logic [5:0]  addrb_q = '0;
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) addrb_q <= ram_addrb;
  end
  assign ram_dob = mem[addrb_q];

  int total = 0;
  int bad   = 0;

  int          mcount = 0;
  logic [5:0]  mwp = '0;
  logic [5:0]  mrp = '0;
  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  logic        e_ovf = 1'b0, e_udf = 1'b0, e_rv = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic model_reset();
    mcount = 0;
    mwp    = '0;
    mrp    = '0;
    mq.delete();
    exp_q.delete();
    e_ovf  = 1'b0;
    e_udf  = 1'b0;
    e_rv   = 1'b0;
  endtask

  // One clock of stimulus; RAM-side strobes are checked before the edge, model advanced at it.
  task automatic cyc(input logic we, input logic [15:0] wd, input logic re);
    bit wacc, racc;
    @(negedge clk);
    #1;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    #1;
    wacc = we && (mcount < 64);
    racc = re && (mcount > 0);
    chk("ram_ena", 32'(ram_ena), 32'(wacc));
    chk("ram_wea", 32'(ram_wea), 32'(wacc));
    chk("ram_enb", 32'(ram_enb), 32'(racc));
    if (wacc) begin
      chk("ram_addra", 32'(ram_addra), 32'(mwp));
      chk("ram_dia", 32'(ram_dia), 32'(wd));
    end
    if (racc) chk("ram_addrb", 32'(ram_addrb), 32'(mrp));
    @(posedge clk);
    e_ovf = we && (mcount == 64);
    e_udf = re && (mcount == 0);
    e_rv  = racc;
    if (racc) begin
      exp_q.push_back(mq.pop_front());
      mrp++;
    end
    if (wacc) begin
      mq.push_back(wd);
      mwp++;
    end
    mcount = mcount + int'(wacc) - int'(racc);
  endtask

  // Monitor: registered outputs against the model, read data against the scoreboard.
  always @(negedge clk) begin
    chk("count", 32'(count), 32'(mcount));
    chk("empty", 32'(empty), 32'(mcount == 0));
    chk("full", 32'(full), 32'(mcount == 64));
    chk("almost_full", 32'(almost_full), 32'(mcount >= 60));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    chk("underflow", 32'(underflow), 32'(e_udf));
    chk("rd_valid", 32'(rd_valid), 32'(e_rv));
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_data_unexpected: got=%0h want=none", rd_data);
      end else begin
        chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Fill 0x0000..0x003F, then one rejected push.
    for (int i = 0; i < 64; i++) cyc(1'b1, 16'(i), 1'b0);
    cyc(1'b1, 16'hDEAD, 1'b0);
    cyc(1'b0, 16'h0, 1'b0);

    // Drain in order, then one rejected pop.
    for (int i = 0; i < 64; i++) cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b0);

    // Push and pop together while empty: only the push lands.
    cyc(1'b1, 16'hBEEF, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b0);

    // Push and pop together while full: only the pop lands, oldest word out.
    for (int i = 0; i < 64; i++) cyc(1'b1, 16'h2000 + 16'(i), 1'b0);
    cyc(1'b1, 16'hFFFF, 1'b1);
    cyc(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 63; i++) cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b0);

    // Read data holds while port B is idle and port A writes elsewhere.
    cyc(1'b1, 16'h1234, 1'b0);
    cyc(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 16'h1111 + 16'(i), 1'b0);
      #1 chk("hold_rd_data", 32'(rd_data), 32'h1234);
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b0);

    // Streaming across the pointer wrap with low occupancy.
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h4000 + 16'(i), 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (i % 8 == 3)      cyc(1'b1, 16'h5000 + 16'(i), 1'b0);
      else if (i % 8 == 7) cyc(1'b0, 16'h0, 1'b1);
      else                 cyc(1'b1, 16'h5000 + 16'(i), 1'b1);
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b0);

    // Asynchronous reset between edges with 37 words held and requests active.
    for (int i = 0; i < 37; i++) cyc(1'b1, 16'h6000 + 16'(i), 1'b0);
    cyc(1'b0, 16'h0, 1'b0);
    @(negedge clk);
    #1;
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 16'h7777;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_almost_full", 32'(almost_full), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_underflow", 32'(underflow), 32'h0);
    chk("rst_ram_ena", 32'(ram_ena), 32'h0);
    chk("rst_ram_enb", 32'(ram_enb), 32'h0);
    @(negedge clk);
    #1;
    rst   = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    cyc(1'b1, 16'hA5A5, 1'b0);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
